// File: rtl/mac_act_buffer_if.sv
// mac_act_buffer_if: producer (MAC result) and consumer (drain) signals of the
// activation buffer. The slave modport is the buffer itself; the master modport
// is whatever drives the MAC side and consumes results.
interface mac_act_buffer_if #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 3
);
   logic                     mac_done;
   logic signed [DATA_W-1:0] mac_out;
   logic signed [DATA_W-1:0] bias;
   logic                     out_ready;
   logic                     out_valid;
   logic signed [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]         level;
   logic                     full;
   logic                     overflow;

   modport master (
      output mac_done, mac_out, bias, out_ready,
      input  out_valid, out_data, level, full, overflow
   );

   modport slave (
      input  mac_done, mac_out, bias, out_ready,
      output out_valid, out_data, level, full, overflow
   );
endinterface

// File: rtl/mac_act_buffer.sv
// mac_act_buffer: captures finished MAC sums, adds a signed bias, saturates to
// DATA_W, optionally applies ReLU, and queues results in a small FIFO drained
// over valid/ready. A slow consumer never stalls the MAC; a result arriving at
// a full FIFO with no pop is dropped and the sticky overflow flag is raised.
// Build option: define MAC_ACT_RELU_EN to clamp negative results to zero.
module mac_act_buffer #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 3
) (
   input logic             clk,
   input logic             reset,
   mac_act_buffer_if.slave bus
);
   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] LVL_FULL = CNT_W'(DEPTH);

   // Clamp a DATA_W+1 bit sum into DATA_W; the top two bits differ only on overflow.
   function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [DATA_W:0] x);
      logic signed [DATA_W-1:0] r;
      if (x[DATA_W] != x[DATA_W-1])
         r = x[DATA_W] ? $signed({1'b1, {(DATA_W-1){1'b0}}})
                       : $signed({1'b0, {(DATA_W-1){1'b1}}});
      else
         r = x[DATA_W-1:0];
      return r;
   endfunction

   // Activation applied after saturation.
   function automatic logic signed [DATA_W-1:0] act_fn(input logic signed [DATA_W-1:0] x);
`ifdef MAC_ACT_RELU_EN
      return x[DATA_W-1] ? '0 : x;
`else
      return x;
`endif
   endfunction

   logic signed [DATA_W:0]   sum_p1;
   logic                     vld_p1;
   logic signed [DATA_W-1:0] res_p2;
   logic                     vld_p2;

   // Stage valids: a done pulse walks through capture and condition stages.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p1 <= bus.mac_done;
         vld_p2 <= vld_p1;
      end
   end

   // Stage data: p1 holds the widened bias sum, p2 the saturated/activated result.
   always_ff @(posedge clk) begin
      if (bus.mac_done)
         sum_p1 <= $signed({bus.mac_out[DATA_W-1], bus.mac_out})
                 + $signed({bus.bias[DATA_W-1], bus.bias});
      if (vld_p1)
         res_p2 <= act_fn(sat_fn(sum_p1));
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  level_q;
   logic              ovf_q;
   logic [DATA_W-1:0] hold_q;
   logic              full_w;
   logic              empty_w;
   logic              pop_w;
   logic              wr_en_w;

   assign full_w  = (level_q == LVL_FULL);
   assign empty_w = (level_q == '0);
   assign pop_w   = !empty_w && bus.out_ready;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign wr_en_w = vld_p2 && (!full_w || pop_w);

   // FIFO storage: data only, no reset needed.
   always_ff @(posedge clk) begin
      if (wr_en_w)
         mem[wr_ptr] <= res_p2;
   end

   // FIFO control: pointers, occupancy, sticky overflow, last popped head.
   // hold_q is reset so out_data is defined before the first push.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         hold_q  <= '0;
      end else begin
         if (wr_en_w)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_w) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            hold_q <= mem[rd_ptr];
         end
         if (vld_p2 && full_w && !pop_w)
            ovf_q <= 1'b1;
         case ({wr_en_w, pop_w})
            2'b10:   level_q <= level_q + CNT_W'(1);
            2'b01:   level_q <= level_q - CNT_W'(1);
            default: ;
         endcase
      end
   end

   assign bus.out_valid = !empty_w;
   assign bus.out_data  = empty_w ? hold_q : mem[rd_ptr];
   assign bus.level     = level_q;
   assign bus.full      = full_w;
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_mac_act_buffer.sv
// tb_mac_act_buffer: directed and randomized stimulus for mac_act_buffer. A
// reference model turns each done pulse into an expected result two edges
// later, decides whether the FIFO accepts or drops it, and queues accepted
// results; a monitor on the falling edge pops and compares every transfer.
`timescale 1ns/1ps
module tb_mac_act_buffer;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 3;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   mac_act_buffer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   mac_act_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int exp_q[$];
   int m_cnt = 0;
   bit m_ovf = 1'b0;
   bit m_v1  = 1'b0;
   bit m_v2  = 1'b0;
   int m_s1  = 0;
   int m_s2  = 0;
   bit m_pop;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_val(input int m, input int b);
      int s;
      s = m + b;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
`ifdef MAC_ACT_RELU_EN
      if (s < 0) s = 0;
`endif
      return s;
   endfunction

   // Reference model: two-edge result delay, FIFO occupancy and drop rule.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_q.delete();
         m_cnt = 0;
         m_ovf = 1'b0;
         m_v1  = 1'b0;
         m_v2  = 1'b0;
      end else begin
         m_pop = (m_cnt != 0) && bus.out_ready;
         if (m_v2) begin
            if (m_cnt == DEPTH && !m_pop) m_ovf = 1'b1;
            else begin
               exp_q.push_back(m_s2);
               m_cnt++;
            end
         end
         if (m_pop) m_cnt--;
         m_v2 = m_v1;
         m_s2 = m_s1;
         m_v1 = bus.mac_done;
         if (bus.mac_done) m_s1 = exp_val(int'(bus.mac_out), int'(bus.bias));
      end
   end

   // Monitor: status against the model, data against the scoreboard queue.
   always @(negedge clk) begin
      chk("out_valid", int'(bus.out_valid), int'(m_cnt != 0));
      chk("level", int'(bus.level), m_cnt);
      chk("full", int'(bus.full), int'(m_cnt == DEPTH));
      chk("overflow", int'(bus.overflow), int'(m_ovf));
      chk("out_data_known", int'($isunknown(bus.out_data)), 0);
      if (bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
         else                   chk("out_data", int'(bus.out_data), exp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic done_pulse(input int m, input int b);
      bus.mac_done = 1'b1;
      bus.mac_out  = DATA_W'(m);
      bus.bias     = DATA_W'(b);
      tick();
      bus.mac_done = 1'b0;
   endtask

   int t3_m[3]   = '{32'h7FF0, -32768, -20};
   int t3_b[3]   = '{256, -1, 5};
`ifdef MAC_ACT_RELU_EN
   int t3_exp[3] = '{32767, 0, 0};
`else
   int t3_exp[3] = '{32767, -32768, -15};
`endif

   initial begin
      int mode;
      bus.mac_done  = 1'b0;
      bus.mac_out   = '0;
      bus.bias      = '0;
      bus.out_ready = 1'b0;

      // 1: reset held with done toggling
      repeat (4) begin
         tick();
         bus.mac_done = ~bus.mac_done;
         bus.mac_out  = 16'sd9;
      end
      tick();
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_level", int'(bus.level), 0);
      chk("rst_overflow", int'(bus.overflow), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      bus.mac_done = 1'b0;
      reset = 1'b1;
      tick();

      // 2: latency
      bus.out_ready = 1'b1;
      done_pulse(100, 5);
      chk("lat_k_valid", int'(bus.out_valid), 0);
      tick();
      chk("lat_k1_valid", int'(bus.out_valid), 0);
      tick();
      chk("lat_k2_valid", int'(bus.out_valid), 1);
      chk("lat_k2_data", int'(bus.out_data), 105);
      chk("lat_k2_level", int'(bus.level), 1);
      tick();
      chk("lat_pop_level", int'(bus.level), 0);

      // 3: saturation / activation
      for (int i = 0; i < 3; i++) begin
         done_pulse(t3_m[i], t3_b[i]);
         tick();
         tick();
         chk("sat_data", int'(bus.out_data), t3_exp[i]);
         tick();
      end

      // 4: full and overflow
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) done_pulse(i, 0);
      tick();
      tick();
      chk("ovf_level", int'(bus.level), 4);
      chk("ovf_full", int'(bus.full), 1);
      chk("ovf_flag", int'(bus.overflow), 1);
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_data", int'(bus.out_data), i);
         tick();
      end
      chk("drain_valid", int'(bus.out_valid), 0);
      chk("drain_level", int'(bus.level), 0);

      // 5: simultaneous push/pop while full, across pointer wrap
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rst2_overflow", int'(bus.overflow), 0);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) done_pulse(10 + i, 0);
      tick();
      tick();
      chk("sim_fill_level", int'(bus.level), 4);
      for (int i = 0; i < 8; i++) begin
         bus.mac_done = 1'b1;
         bus.mac_out  = DATA_W'(20 + i);
         bus.bias     = '0;
         if (i == 2) bus.out_ready = 1'b1;
         tick();
         if (i >= 2) begin
            chk("sim_level", int'(bus.level), 4);
            chk("sim_overflow", int'(bus.overflow), 0);
         end
      end
      bus.mac_done = 1'b0;
      repeat (2) begin
         tick();
         chk("sim_tail_level", int'(bus.level), 4);
      end
      repeat (5) tick();
      chk("sim_end_level", int'(bus.level), 0);
      chk("sim_end_overflow", int'(bus.overflow), 0);

      // 6: reset mid-operation
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) done_pulse(i * 3, 1);
      chk("mid_level_before", int'(bus.level), 3);
      reset = 1'b0;
      #1;
      chk("mid_level", int'(bus.level), 0);
      chk("mid_valid", int'(bus.out_valid), 0);
      tick();
      reset = 1'b1;
      tick();
      tick();
      chk("mid_quiet", int'(bus.out_valid), 0);
      bus.out_ready = 1'b1;
      done_pulse(7, 0);
      tick();
      tick();
      chk("mid_post_valid", int'(bus.out_valid), 1);
      chk("mid_post_data", int'(bus.out_data), 7);
      tick();

      // Randomized traffic with varying consumer speed and one reset pulse
      for (int i = 0; i < 400; i++) begin
         mode = int'($urandom_range(0, 3));
         bus.mac_done = ($urandom_range(0, 99) < 60);
         case (mode)
            0: begin
               bus.mac_out = DATA_W'($urandom);
               bus.bias    = DATA_W'($urandom);
            end
            1: begin
               bus.mac_out = DATA_W'(int'($urandom_range(0, 400)) - 200);
               bus.bias    = DATA_W'(int'($urandom_range(0, 400)) - 200);
            end
            2: begin
               bus.mac_out = DATA_W'(32767 - int'($urandom_range(0, 300)));
               bus.bias    = DATA_W'(int'($urandom_range(0, 600)));
            end
            default: begin
               bus.mac_out = DATA_W'(-32768 + int'($urandom_range(0, 300)));
               bus.bias    = DATA_W'(-int'($urandom_range(0, 600)));
            end
         endcase
         bus.out_ready = ($urandom_range(0, 99) < (((i / 100) % 2) != 0 ? 30 : 80));
         if (i == 200) reset = 1'b0;
         if (i == 203) reset = 1'b1;
         tick();
      end
      bus.mac_done  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (8) tick();
      chk("rand_drain_level", int'(bus.level), 0);
      chk("rand_outstanding", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
